// File: rtl/inv_mix_columns_iter.sv
// inv_mix_columns_iter: iterative AES InvMixColumns, COLS_PER_CYCLE columns per clock.
// Valid/ready on both sides; per-block bypass covers the final decrypt round.
module inv_mix_columns_iter #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_bypass,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 &&
       COLS_PER_CYCLE != 4) begin : g_bad_cpc
      $error("COLS_PER_CYCLE must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } st_t;

   st_t          st;
   logic [1:0]   col;
   logic [127:0] state_q;
   logic [127:0] nxt;
   logic         byp_q;
   logic         up_q;
   logic         accept;
   logic         last;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // 9/B/D/E multiples built from the x2, x4, x8 xtime chain
   function automatic logic [31:0] inv_col(input logic [31:0] c);
      logic [7:0] a  [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      logic [31:0] o;
      o = '0;
      for (int r = 0; r < 4; r++) begin
         a[2'(r)]  = c[31-8*r -: 8];
         x2        = xt(a[2'(r)]);
         x4        = xt(x2);
         x8        = xt(x4);
         m9[2'(r)] = x8 ^ a[2'(r)];
         mb[2'(r)] = x8 ^ x2 ^ a[2'(r)];
         md[2'(r)] = x8 ^ x4 ^ a[2'(r)];
         me[2'(r)] = x8 ^ x4 ^ x2;
      end
      for (int r = 0; r < 4; r++) begin
         o[31-8*r -: 8] = me[2'(r)] ^ mb[2'(r+1)] ^
                          md[2'(r+2)] ^ m9[2'(r+3)];
      end
      return o;
   endfunction

   always_comb begin
      logic [1:0] ci;
      ci  = '0;
      nxt = state_q;
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
         ci = col + 2'(k);
         if (!byp_q) begin
            nxt[127-32*ci -: 32] = inv_col(state_q[127-32*ci -: 32]);
         end
      end
   end

   assign last      = (col + 2'(COLS_PER_CYCLE - 1)) == 2'd3;
   // up_q holds in_ready low until the first edge after reset release
   assign in_ready  = up_q & ((st == IDLE) | ((st == DONE) & out_ready));
   assign accept    = in_valid & in_ready;
   assign out_valid = (st == DONE);
   assign out_data  = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= IDLE;
         col     <= '0;
         state_q <= '0;
         byp_q   <= 1'b0;
         up_q    <= 1'b0;
      end else begin
         up_q <= 1'b1;
         if (accept) begin
            state_q <= in_data;
            byp_q   <= in_bypass;
            col     <= '0;
            st      <= BUSY;
         end else begin
            unique case (st)
               BUSY: begin
                  state_q <= nxt;
                  col     <= col + 2'(COLS_PER_CYCLE);
                  if (last) st <= DONE;
               end
               DONE: begin
                  if (out_ready) st <= IDLE;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Scoreboard bench for inv_mix_columns_iter at COLS_PER_CYCLE 1, 2 and 4.
// Expected states are queued at drive time and compared on output handshakes.
module tb_inv_mix_columns_iter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [2:0]   in_valid, in_ready, in_bypass;
   logic [2:0]   out_valid, out_ready;
   logic [127:0] in_data  [3];
   logic [127:0] out_data [3];

   int           checks = 0;
   int           failures = 0;
   int           cyc = 0;
   logic [127:0] exp_q[$];
   int           acc_q[$];
   logic [2:0]   pv = '0;

   localparam logic [127:0] V1 = 128'h8E4DA1BC_9FDC589D_4D7EBDF8_D5D5D7D6;
   localparam logic [127:0] E1 = 128'hDB135345_F20A225C_2D26314C_D4D4D4D5;
   localparam logic [127:0] F1 = {4{32'h01010101}};
   localparam logic [127:0] F2 = {4{32'hC6C6C6C6}};
   localparam logic [127:0] BV = 128'h00112233_44556677_8899AABB_CCDDEEFF;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   inv_mix_columns_iter #(.COLS_PER_CYCLE(1)) u_c1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_bypass(in_bypass[0]), .in_data(in_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_data(out_data[0])
   );

   inv_mix_columns_iter #(.COLS_PER_CYCLE(2)) u_c2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_bypass(in_bypass[1]), .in_data(in_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_data(out_data[1])
   );

   inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) u_c4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_bypass(in_bypass[2]), .in_data(in_data[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .out_data(out_data[2])
   );

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int lat(input int d);
      return (d == 0) ? 4 : (d == 1) ? 2 : 1;
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // forward MixColumns reference
   function automatic logic [127:0] fwd_mc(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a [4];
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) a[r] = s[127-32*c-8*r -: 8];
         for (int r = 0; r < 4; r++) begin
            o[127-32*c-8*r -: 8] = xt(a[r]) ^ xt(a[(r+1)%4]) ^ a[(r+1)%4]
                                   ^ a[(r+2)%4] ^ a[(r+3)%4];
         end
      end
      return o;
   endfunction

   always @(posedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < 3; d++) begin
            if (in_valid[d] && in_ready[d]) acc_q.push_back(cyc);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         pv = '0;
      end else begin
         for (int d = 0; d < 3; d++) begin
            if (out_valid[d] && !pv[d]) begin
               if (acc_q.size() == 0) begin
                  chk("spurious_valid", 128'(out_valid[d]), 128'd0);
               end else begin
                  int a;
                  a = acc_q.pop_front();
                  chk("latency", 128'(cyc - a - 1), 128'(lat(d)));
               end
            end
            if (out_valid[d] && out_ready[d]) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_out", 128'(out_valid[d]), 128'd0);
               end else begin
                  chk("data", out_data[d], exp_q.pop_front());
               end
            end
            pv[d] = out_valid[d];
         end
      end
   end

   task automatic send(input int d, input logic [127:0] data,
                       input logic byp, input logic [127:0] exp);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      in_valid[d]  = 1'b1;
      in_data[d]   = data;
      in_bypass[d] = byp;
      exp_q.push_back(exp);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready[d]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("send_timeout", 128'(ok), 128'd1);
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      if (exp_q.size() != 0) chk("drain_timeout", 128'(exp_q.size()), 128'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout got=%0d exp=0", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [127:0] s;
      bit           seen;
      rst_n     = 1'b0;
      in_valid  = '0;
      in_bypass = '0;
      out_ready = '1;
      for (int d = 0; d < 3; d++) in_data[d] = '0;

      #2;
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_in_ready", 128'(in_ready), 128'd0);
      chk("rst_out_data", out_data[0], 128'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("in_ready_pre_edge", 128'(in_ready), 128'd0);
      @(posedge clk); #1;
      chk("in_ready_post_edge", 128'(in_ready), 128'd7);

      // column vector, fixed points
      send(0, V1, 1'b0, E1);
      drain();
      send(0, F1, 1'b0, F1);
      send(0, F2, 1'b0, F2);
      drain();

      // bypass, then a normal block
      send(0, BV, 1'b1, BV);
      send(0, V1, 1'b0, E1);
      drain();

      // backpressure with same-cycle accept on release
      @(posedge clk); #1;
      out_ready[0] = 1'b0;
      send(0, V1, 1'b0, E1);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid[0]) begin
            seen = 1'b1;
            break;
         end
      end
      chk("bp_reach_done", 128'(seen), 128'd1);
      @(posedge clk); #1;
      in_valid[0] = 1'b1;
      in_data[0]  = F1;
      in_bypass[0] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_valid", 128'(out_valid[0]), 128'd1);
         chk("bp_data", out_data[0], E1);
         chk("bp_in_ready", 128'(in_ready[0]), 128'd0);
      end
      @(posedge clk); #1;
      out_ready[0] = 1'b1;
      exp_q.push_back(F1);
      @(negedge clk);
      chk("same_cycle_accept", 128'(in_ready[0]), 128'd1);
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      drain();

      // reset during BUSY at col=2
      send(0, V1, 1'b0, E1);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 128'(out_valid[0]), 128'd0);
      chk("mid_rst_in_ready", 128'(in_ready[0]), 128'd0);
      chk("mid_rst_out_data", out_data[0], 128'd0);
      exp_q.delete();
      acc_q.delete();
      repeat (3) begin
         @(negedge clk);
         chk("mid_rst_no_out", 128'(out_valid), 128'd0);
      end
      rst_n = 1'b1;
      send(0, V1, 1'b0, E1);
      drain();

      // random round trip at each column rate
      for (int d = 0; d < 3; d++) begin
         for (int n = 0; n < 1000; n++) begin
            s = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(d, fwd_mc(s), 1'b0, s);
         end
         drain();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
